// File: rtl/corsel_2l_block_if.sv
// rtl/corsel_2l_block_if.sv - operand/result bundle for the two-stage residue correction pipeline
// Optional err_flag signal is present when CORSEL_2L_ERR_FLAG_EN is defined.
interface corsel_2l_block_if #(
    parameter int unsigned DATA_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] A;
    logic [1:0]            sign_in;
    logic [DATA_WIDTH-1:0] A_out;
    logic [DATA_WIDTH-1:0] cor_result;
`ifdef CORSEL_2L_ERR_FLAG_EN
    logic                  err_flag;

    modport master (output A, sign_in, input A_out, cor_result, err_flag);
    modport slave  (input A, sign_in, output A_out, cor_result, err_flag);
`else
    modport master (output A, sign_in, input A_out, cor_result);
    modport slave  (input A, sign_in, output A_out, cor_result);
`endif
endinterface

// File: rtl/corsel_2l_block.sv
// rtl/corsel_2l_block.sv - two-stage pipelined residue +/- DIGIT_CORRECT mod MODULUS
// Optional macro CORSEL_2L_ERR_FLAG_EN adds a latency-matched err_flag output.
module corsel_2l_block #(
    parameter int unsigned DATA_WIDTH    = 18,
    parameter int unsigned MODULUS       = 177147,
    parameter int unsigned DIGIT_CORRECT = 33343
) (
    input  logic              clk,
    input  logic              rst_n,
    corsel_2l_block_if.slave  bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [W:0] MOD_W1 = (W+1)'(MODULUS);
    localparam logic [W:0] DC_W1  = (W+1)'(DIGIT_CORRECT);

    // Stage 1: raw candidates keep their carry/borrow bit for stage-2 reduction
    logic [W-1:0] a1_q,   a1_d;
    logic [1:0]   sign1_q, sign1_d;
    logic [W:0]   add1_q, add1_d;
    logic [W:0]   sub1_q, sub1_d;

    logic [W-1:0] a2_q,   a2_d;
    logic [W-1:0] res2_q, res2_d;

    logic [W+1:0] add_red;
    logic [W:0]   sub_fix;
    logic [W-1:0] add_res;
    logic [W-1:0] sub_res;

    always_comb begin
        a1_d    = bus.A;
        sign1_d = bus.sign_in;
        add1_d  = {1'b0, bus.A} + DC_W1;
        sub1_d  = {1'b0, bus.A} - DC_W1;
    end

    // No borrow from (sum - MODULUS) means the sum reached MODULUS and must wrap
    always_comb begin
        add_red = {1'b0, add1_q} - {1'b0, MOD_W1};
        sub_fix = sub1_q + MOD_W1;
        add_res = add_red[W+1] ? add1_q[W-1:0] : add_red[W-1:0];
        sub_res = sub1_q[W]    ? sub_fix[W-1:0] : sub1_q[W-1:0];
        a2_d    = a1_q;
        case (sign1_q)
            2'd1:    res2_d = add_res;
            2'd2:    res2_d = sub_res;
            default: res2_d = a1_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q    <= '0;
            sign1_q <= '0;
            add1_q  <= '0;
            sub1_q  <= '0;
            a2_q    <= '0;
            res2_q  <= '0;
        end else begin
            a1_q    <= a1_d;
            sign1_q <= sign1_d;
            add1_q  <= add1_d;
            sub1_q  <= sub1_d;
            a2_q    <= a2_d;
            res2_q  <= res2_d;
        end
    end

    assign bus.A_out      = a2_q;
    assign bus.cor_result = res2_q;

`ifdef CORSEL_2L_ERR_FLAG_EN
    logic err1_q, err1_d;
    logic err2_q;

    assign err1_d = (bus.sign_in == 2'd3) || ({1'b0, bus.A} >= MOD_W1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            err1_q <= err1_d;
            err2_q <= err1_q;
        end
    end

    assign bus.err_flag = err2_q;
`endif
endmodule

// File: tb/tb_corsel_2l_block.sv
// tb/tb_corsel_2l_block.sv - directed vector bench for corsel_2l_block
module tb_corsel_2l_block;
    localparam int W = 18;

    typedef struct {
        logic [W-1:0] a;
        logic [1:0]   sign;
        logic [W-1:0] exp_res;
        logic         exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    corsel_2l_block_if #(.DATA_WIDTH(W)) bus ();

    corsel_2l_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    vec_t vecs[13];

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{18'h12345, 2'd0, 18'h12345, 1'b0};
        vecs[1]  = '{18'h12345, 2'd1, 18'h1A584, 1'b0};
        vecs[2]  = '{18'h12345, 2'd2, 18'h0A106, 1'b0};
        vecs[3]  = '{18'd1000,  2'd2, 18'h235A4, 1'b0};
        vecs[4]  = '{18'h26543, 2'd1, 18'h03387, 1'b0};
        vecs[5]  = '{18'h12345, 2'd3, 18'h12345, 1'b1};
        vecs[6]  = '{18'd0,      2'd2, 18'd143804, 1'b0};
        vecs[7]  = '{18'd177146, 2'd1, 18'd33342,  1'b0};
        vecs[8]  = '{18'd143804, 2'd1, 18'd0,      1'b0};
        vecs[9]  = '{18'd33343,  2'd2, 18'd0,      1'b0};
        vecs[10] = '{18'd33342,  2'd2, 18'd177146, 1'b0};
        vecs[11] = '{18'd0,      2'd1, 18'd33343,  1'b0};
        vecs[12] = '{18'd143803, 2'd1, 18'd177146, 1'b0};

        rst_n       = 1'b0;
        bus.A       = 18'h12345;
        bus.sign_in = 2'd1;
        #1;
        check("reset_res", 32'(bus.cor_result), 32'd0);
        check("reset_aout", 32'(bus.A_out), 32'd0);
        repeat (2) @(negedge clk);
        check("reset_hold_res", 32'(bus.cor_result), 32'd0);
        rst_n = 1'b1;

        // Back-to-back stream: vector i-2 must appear at iteration i
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("res[%0d]", i-2), 32'(bus.cor_result), 32'(vecs[i-2].exp_res));
                check($sformatf("aout[%0d]", i-2), 32'(bus.A_out), 32'(vecs[i-2].a));
`ifdef CORSEL_2L_ERR_FLAG_EN
                check($sformatf("err[%0d]", i-2), 32'(bus.err_flag), 32'(vecs[i-2].exp_err));
`endif
            end
            if (i < 13) begin
                bus.A       = vecs[i].a;
                bus.sign_in = vecs[i].sign;
            end else begin
                bus.A       = '0;
                bus.sign_in = 2'd0;
            end
        end

`ifdef CORSEL_2L_ERR_FLAG_EN
        @(negedge clk);
        bus.A       = 18'h2B3FB;
        bus.sign_in = 2'd0;
        @(negedge clk);
        bus.A       = 18'd5;
        @(negedge clk);
        check("err_oor", 32'(bus.err_flag), 32'd1);
        @(negedge clk);
        check("err_clear", 32'(bus.err_flag), 32'd0);
`endif

        // Mid-stream reset: outputs clear immediately and in-flight data is dropped
        @(negedge clk);
        bus.A       = 18'h26543;
        bus.sign_in = 2'd1;
        @(negedge clk);
        bus.A       = 18'h12345;
        bus.sign_in = 2'd2;
        @(negedge clk);
        check("pre_rst_res", 32'(bus.cor_result), 32'h03387);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res", 32'(bus.cor_result), 32'd0);
        check("mid_rst_aout", 32'(bus.A_out), 32'd0);
        bus.A       = '0;
        bus.sign_in = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_res", 32'(bus.cor_result), 32'd0);
        check("post_rst_aout", 32'(bus.A_out), 32'd0);
        bus.A       = 18'h12345;
        bus.sign_in = 2'd1;
        @(negedge clk);
        bus.A       = '0;
        bus.sign_in = 2'd0;
        @(negedge clk);
        check("first_after_rst", 32'(bus.cor_result), 32'h1A584);
        check("first_after_rst_aout", 32'(bus.A_out), 32'h12345);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/corsel_2l_block.md
CORSEL_2L_BLOCK -- requirements
Module: corsel_2l

Interface
REQ-001 Parameter DATA_WIDTH, default 18: width of A, A_out and cor_result.
REQ-002 Parameter MODULUS, default 177147: residue modulus; all arithmetic is mod MODULUS; MODULUS < 2^DATA_WIDTH.
REQ-003 Parameter DIGIT_CORRECT, default 33343: correction constant; 0 <= DIGIT_CORRECT < MODULUS.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port A, input, DATA_WIDTH: residue operand, 0 <= A < MODULUS.
REQ-007 Port sign_in, input, 2: correction select; 0 = none, 1 = add, 2 = subtract, 3 = reserved.
REQ-008 Port A_out, output, DATA_WIDTH: A delayed to align with cor_result.
REQ-009 Port cor_result, output, DATA_WIDTH: corrected residue.

Function
REQ-010 sign_in=0: cor_result = A.
REQ-011 sign_in=1: cor_result = (A + DIGIT_CORRECT) mod MODULUS, via one conditional subtract of MODULUS.
REQ-012 sign_in=2: cor_result = (A - DIGIT_CORRECT) mod MODULUS, via one conditional add of MODULUS when A < DIGIT_CORRECT.
REQ-013 sign_in=3: cor_result = A; the code is treated as no correction.
REQ-014 Intermediate sums are DATA_WIDTH+1 bits wide; the carry/borrow bit selects the wrap branch; nothing is truncated before reduction.
REQ-015 Two register stages. Stage 1 registers A, sign_in and both raw candidates (A+DIGIT_CORRECT, A-DIGIT_CORRECT). Stage 2 registers the reduced, selected result and the delayed A.
REQ-016 Inputs sampled at rising edge N appear on A_out and cor_result after rising edge N+1; latency is 2 cycles from input application.
REQ-017 Fully pipelined, one new operand per cycle; no stall, no handshake.
REQ-018 A_out always equals the A that produced the concurrent cor_result.
REQ-019 A >= MODULUS is out of contract; outputs for such inputs are don't-care but deterministic.

Reset
REQ-020 rst_n low asynchronously clears all pipeline registers; A_out = 0 and cor_result = 0 while rst_n is low.
REQ-021 After rst_n deasserts, the first valid output appears 2 cycles after the first sampled input.
REQ-022 Reset asserted mid-stream discards all in-flight operands.

Configuration
REQ-023 Macro CORSEL_2L_ERR_FLAG_EN defined: adds output err_flag (1 bit), registered with the same 2-cycle latency and reset to 0. err_flag = 1 when sign_in == 3 or A >= MODULUS for that operand.
REQ-024 Macro CORSEL_2L_ERR_FLAG_EN undefined: no err_flag port and no related logic; all other behaviour is identical.

Verification
REQ-025 Default parameters, A=0x12345, sign_in=0 -> 2 cycles later cor_result=0x12345, A_out=0x12345.
REQ-026 A=0x12345, sign_in=1 -> cor_result=0x1A584 (107908).
REQ-027 A=0x12345, sign_in=2 -> cor_result=0x0A106 (41222); A=1000, sign_in=2 -> cor_result=0x235A4 (144804, borrow wrap).
REQ-028 A=0x26543, sign_in=1 -> cor_result=0x03387 (13191, carry wrap).
REQ-029 Back-to-back stream of the vectors above, one per cycle -> results in order, each exactly 2 cycles after its input, with A_out aligned. Assert rst_n low mid-stream -> outputs read 0 immediately.
REQ-030 CORSEL_2L_ERR_FLAG_EN defined, sign_in=3, A=0x12345 -> cor_result=0x12345 and err_flag=1; A=0x2B3FB (>= MODULUS) -> err_flag=1.
